jk_bank_arbiter: RTL and testbench
==================================

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_FF, default 4, giving the number of JK flip-flops in the shared bank.
REQ-002 The block SHALL have parameter ADDR_W, default 2, giving the flop-select width; it SHALL equal log2(NUM_FF).
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Ports req0_valid / req1_valid  input  1  requester has a command pending.
REQ-006 Ports req0_ready / req1_ready  output  1  command accepted on this edge.
REQ-007 Ports req0_addr / req1_addr  input  ADDR_W  target flop index.
REQ-008 Ports req0_op / req1_op  input  2  command: 00 hold, 01 clear (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1).
REQ-009 Port q  output  NUM_FF  current flop-bank state.
REQ-010 Port done  output  1  one-cycle completion pulse.
REQ-011 Port done_id  output  1  requester index of the completed command.

Function
REQ-012 The FSM SHALL have three states: IDLE, APPLY and RESP; transitions SHALL be IDLE->APPLY on handshake, APPLY->RESP always, and RESP->IDLE always.
REQ-013 In IDLE, the block SHALL assert ready combinationally to exactly one valid requester (the grant winner); ready SHALL be 0 in APPLY and RESP.
REQ-014 A handshake (valid && ready) SHALL latch addr, op and requester id.
REQ-015 In APPLY, the block SHALL drive the latched op as J/K to flop[addr] only and J=K=0 to all other flops.
REQ-016 q SHALL reflect the new value from the edge ending APPLY, i.e. two edges after the handshake edge.
REQ-017 In RESP, the block SHALL assert done=1 and done_id=latched id for exactly one cycle.
REQ-018 Maximum throughput SHALL be one command per 3 cycles.
REQ-019 Requesters SHALL hold valid, addr and op stable until ready; a valid withdrawn before ready SHALL leave no side effect.
REQ-020 With both valid in IDLE, the block SHALL grant the requester not granted last; with one valid, it SHALL grant that one regardless of history.
REQ-021 An op of 00 (hold) SHALL still complete the full handshake and assert done with q unchanged.
REQ-022 An addr >= NUM_FF SHALL be treated as a hold: done asserted, q unchanged.

Reset
REQ-023 On rst, the block SHALL set q=0, state=IDLE, done=0, done_id=0, ready=0 and last_grant=1, so that requester 0 wins the first tie.
REQ-024 rst asserted in APPLY or RESP SHALL discard the in-flight command, without updating q and without asserting done.
REQ-025 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-026 With macro JK_ARB_RR_EN defined, arbitration SHALL be round-robin per REQ-020.
REQ-027 Without JK_ARB_RR_EN, arbitration SHALL be fixed priority with req0 always winning a tie; last_grant SHALL still exist but have no effect on arbitration.

Structure
REQ-028 Package jk_arb_pkg SHALL hold the op encoding constants (OP_HOLD, OP_CLR, OP_SET, OP_TGL) and the FSM state enum.
REQ-029 The design SHALL contain one sub-module, jk_ff (clk, rst, j, k, q), instantiated NUM_FF times; its behaviour SHALL be: reset q=0; 00 hold, 01 clear, 10 set, 11 toggle.

Verification
REQ-030 Scenario: after reset, req0 requests op=10, addr=2 -> req0_ready=1 in cycle 0; q=4'b0100 after edge 2; done=1 with done_id=0 in cycle 2.
REQ-031 Scenario: two toggles on addr=0 from req1 -> q[0] goes 1 then 0; two done pulses at least 3 cycles apart.
REQ-032 Scenario: both requesters valid continuously with JK_ARB_RR_EN defined -> grants alternate 0,1,0,1; without the macro -> grants are always 0.
REQ-033 Scenario: rst asserted in APPLY of a set to addr=3 -> q stays 0; no done pulse; req0 wins the next tie.
REQ-034 Scenario: op=00 and addr=1 on a bank with q=4'b1010 -> done pulses; q remains 4'b1010; ready is low during APPLY and RESP.

Source files
------------

// File: rtl/jk_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_arb_pkg
//  Description : Shared JK-command encodings and arbiter FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package jk_arb_pkg;

    // Command encoding, bit 1 = J, bit 0 = K
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage : jk_arb_pkg
`default_nettype wire

// File: rtl/jk_ff.sv
`default_nettype none
// ============================================================================
//  Module      : jk_ff
//  Description : Single JK flip-flop with synchronous active-high reset.
//  Revision    : 1.0  initial release
// ============================================================================
module jk_ff
    import jk_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    // JK update: hold, clear, set or toggle depending on {j,k}
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                OP_CLR:  q <= 1'b0;
                OP_SET:  q <= 1'b1;
                OP_TGL:  q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule : jk_ff
`default_nettype wire

// File: rtl/jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : jk_bank_arbiter
//  Description : Two-requester arbiter driving a shared bank of JK flops.
//                Each accepted command runs IDLE -> APPLY -> RESP.
//                Build option: JK_ARB_RR_EN selects round-robin tie-break;
//                without it requester 0 always wins a tie.
//  Revision    : 1.0  initial release
// ============================================================================
module jk_bank_arbiter
    import jk_arb_pkg::*;
#(
    parameter int NUM_FF = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [1:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [1:0]        req1_op,
    output logic [NUM_FF-1:0] q,
    output logic              done,
    output logic              done_id
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        op_q, op_d;
    logic              id_q, id_d;
    logic              last_grant_q, last_grant_d;

    logic              grant_vld;
    logic              grant_id;

    // Grant selection; only offered in IDLE and never while reset is high
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state_q == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
`ifdef JK_ARB_RR_EN
                grant_id  = ~last_grant_q;
`else
                grant_id  = 1'b0;
`endif
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld & ~grant_id;
    assign req1_ready = grant_vld &  grant_id;
    assign done_id    = id_q;

    // Next-state, command capture and completion pulse
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        op_d         = op_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d      = APPLY;
                    addr_d       = grant_id ? req1_addr : req0_addr;
                    op_d         = grant_id ? req1_op   : req0_op;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                end
            end
            APPLY: state_d = RESP;
            RESP: begin
                state_d = IDLE;
                done    = ~rst;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-command registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            op_q         <= OP_HOLD;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // One flop per bank slot; an out-of-range address matches no slot,
    // so it degenerates to a hold without extra logic.
    generate
        for (genvar i = 0; i < NUM_FF; i++) begin : g_ff
            logic sel;
            assign sel = (state_q == APPLY) && (addr_q == ADDR_W'(i));

            jk_ff u_ff (
                .clk (clk),
                .rst (rst),
                .j   (sel & op_q[1]),
                .k   (sel & op_q[0]),
                .q   (q[i])
            );
        end
    endgenerate

endmodule : jk_bank_arbiter
`default_nettype wire

// File: tb/tb_jk_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_bank_arbiter
//  Description : Self-checking bench for jk_bank_arbiter against a
//                transaction-level model (grant rule, completion time,
//                bank update arithmetic). Honours JK_ARB_RR_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jk_bank_arbiter;

    localparam int NUM_FF = 4;
    localparam int ADDR_W = 2;
`ifdef JK_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_valid = 1'b0;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr  = '0;
    logic [ADDR_W-1:0] req1_addr  = '0;
    logic [1:0]        req0_op    = '0;
    logic [1:0]        req1_op    = '0;
    logic              req0_ready;
    logic              req1_ready;
    logic [NUM_FF-1:0] q;
    logic              done;
    logic              done_id;

    jk_bank_arbiter #(
        .NUM_FF (NUM_FF),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_op    (req1_op),
        .q          (q),
        .done       (done),
        .done_id    (done_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: command-level timing as cycle numbers
    int                cyc      = 0;
    int                done_at  = -1;
    int                free_at  = 0;
    int                last_g   = 1;
    int                last_id  = 0;
    int                p_addr   = 0;
    int                p_op     = 0;
    bit                model_ok = 1'b0;
    logic [NUM_FF-1:0] bank     = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [NUM_FF-1:0] apply_op(input logic [NUM_FF-1:0] b,
                                                   input int a, input int op);
        logic [NUM_FF-1:0] n;
        n = b;
        if (a < NUM_FF) begin
            case (op)
                1: n[a] = 1'b0;
                2: n[a] = 1'b1;
                3: n[a] = ~b[a];
                default: ;
            endcase
        end
        return n;
    endfunction

    // One clock cycle: drive inputs, compare outputs with model, advance model.
    // w returns the requester the model expects to be granted (-1 = none).
    task automatic step(input logic r,
                        input logic v0, input logic [ADDR_W-1:0] a0, input logic [1:0] o0,
                        input logic v1, input logic [ADDR_W-1:0] a1, input logic [1:0] o1,
                        output int w);
        @(negedge clk);
        rst        = r;
        req0_valid = v0;
        req0_addr  = a0;
        req0_op    = o0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_op    = o1;
        #1;
        if (cyc == done_at) bank = apply_op(bank, p_addr, p_op);
        w = -1;
        if (!r && cyc >= free_at) begin
            if (v0 && v1)  w = RR ? (1 - last_g) : 0;
            else if (v0)   w = 0;
            else if (v1)   w = 1;
        end
        if (model_ok) begin
            chk("ready0", 32'(req0_ready), 32'(w == 0));
            chk("ready1", 32'(req1_ready), 32'(w == 1));
            chk("done",   32'(done),       32'(!r && cyc == done_at));
            if (!r && cyc == done_at) chk("done_id", 32'(done_id), 32'(last_id));
            chk("q", 32'(q), 32'(bank));
        end
        if (r) begin
            bank     = '0;
            last_g   = 1;
            last_id  = 0;
            done_at  = -1;
            free_at  = cyc + 1;
            model_ok = 1'b1;
        end else if (w >= 0) begin
            p_addr  = (w == 1) ? int'(a1) : int'(a0);
            p_op    = (w == 1) ? int'(o1) : int'(o0);
            last_g  = w;
            last_id = w;
            done_at = cyc + 2;
            free_at = cyc + 3;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        int w;
        repeat (n) step(1'b0, 1'b0, '0, 2'b00, 1'b0, '0, 2'b00, w);
    endtask

    task automatic rst_cyc();
        int w;
        step(1'b1, 1'b0, '0, 2'b00, 1'b0, '0, 2'b00, w);
    endtask

    task automatic send(input int id, input logic [ADDR_W-1:0] a, input logic [1:0] o);
        int w;
        if (id == 0) step(1'b0, 1'b1, a, o, 1'b0, '0, 2'b00, w);
        else         step(1'b0, 1'b0, '0, 2'b00, 1'b1, a, o, w);
    endtask

    initial begin
        int                w;
        bit                dense;
        bit                r;
        logic              pv0, pv1;
        logic [ADDR_W-1:0] pa0, pa1;
        logic [1:0]        po0, po1;

        // Reset state
        rst_cyc();
        rst_cyc();
        idle(1);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_q", 32'(q), 32'd0);

        // Set addr 2 from requester 0
        send(0, 2'd2, 2'b10);
        idle(2);
        chk("set_q", 32'(q), 32'h4);
        chk("set_done", 32'(done), 32'd1);
        idle(1);

        // Two toggles of addr 0 from requester 1
        send(1, 2'd0, 2'b11);
        idle(3);
        chk("tgl1_q0", 32'(q[0]), 32'd1);
        send(1, 2'd0, 2'b11);
        idle(3);
        chk("tgl2_q0", 32'(q[0]), 32'd0);

        // Reset during APPLY discards the command; req0 wins the next tie
        rst_cyc();
        send(0, 2'd3, 2'b10);
        step(1'b1, 1'b0, '0, 2'b00, 1'b0, '0, 2'b00, w);
        idle(2);
        chk("rst_apply_q", 32'(q), 32'd0);
        step(1'b0, 1'b1, 2'd1, 2'b10, 1'b1, 2'd2, 2'b10, w);
        chk("rst_tie_r0", 32'(req0_ready), 32'd1);
        idle(3);

        // Hold op on a populated bank
        rst_cyc();
        send(0, 2'd1, 2'b10);
        idle(3);
        send(1, 2'd3, 2'b10);
        idle(3);
        chk("bank_1010", 32'(q), 32'hA);
        send(0, 2'd1, 2'b00);
        idle(2);
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_q", 32'(q), 32'hA);
        idle(1);

        // Randomized traffic: dense contention first, then sparse with
        // withdrawals, occasional resets and junk on idle lanes
        pv0 = 1'b0; pv1 = 1'b0;
        pa0 = '0; pa1 = '0; po0 = '0; po1 = '0;
        for (int i = 0; i < 1600; i++) begin
            dense = (i < 300);
            r     = ($urandom_range(0, 99) < 2);
            if (!pv0 && (dense || $urandom_range(0, 3) == 0)) begin
                pv0 = 1'b1; pa0 = ADDR_W'($urandom); po0 = 2'($urandom);
            end else if (pv0 && !dense && $urandom_range(0, 31) == 0) begin
                pv0 = 1'b0;
            end else if (!pv0) begin
                pa0 = ADDR_W'($urandom); po0 = 2'($urandom);
            end
            if (!pv1 && (dense || $urandom_range(0, 3) == 0)) begin
                pv1 = 1'b1; pa1 = ADDR_W'($urandom); po1 = 2'($urandom);
            end else if (pv1 && !dense && $urandom_range(0, 31) == 0) begin
                pv1 = 1'b0;
            end else if (!pv1) begin
                pa1 = ADDR_W'($urandom); po1 = 2'($urandom);
            end
            step(r, pv0, pa0, po0, pv1, pa1, po1, w);
            if (w == 0) pv0 = 1'b0;
            if (w == 1) pv1 = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_jk_bank_arbiter
`default_nettype wire
